// File: rtl/jk_pkg.sv
// Shared types, JK excitation codes and the per-bit excitation function for the JK bank driver.
// Defining JK_TOGGLE_EN resolves excitation don't-cares to 1, so state changes are made by toggling.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Codes are packed as {j,k}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Returns the {j,k} pair that moves one flop from q to q_next in a single edge.
    function automatic logic [1:0] excite_bit(input logic q, input logic q_next);
        logic [1:0] jk;
`ifdef JK_TOGGLE_EN
        case ({q, q_next})
            2'b00:   jk = JK_RESET;
            2'b01:   jk = JK_TOGGLE;
            2'b10:   jk = JK_TOGGLE;
            default: jk = JK_SET;
        endcase
`else
        case ({q, q_next})
            2'b00:   jk = JK_HOLD;
            2'b01:   jk = JK_SET;
            2'b10:   jk = JK_RESET;
            default: jk = JK_HOLD;
        endcase
`endif
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational WIDTH-wide J/K excitation: current bank state x desired state -> j, k.
// The per-bit table (and its JK_TOGGLE_EN variant) lives in jk_pkg::excite_bit.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign {j[gi], k[gi]} = excite_bit(q[gi], tgt[gi]);
        end
    endgenerate

endmodule

// File: rtl/jk_drive_seq.sv
// Drives a bank of JK flops to a requested word, verifies Q feedback, retries, and flags done/err.
// Excitation style is selected by JK_TOGGLE_EN (see jk_pkg); the default build never toggles.
module jk_drive_seq
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [WIDTH-1:0]     tgt_data,
    input  logic [WIDTH-1:0]     q_fb,
    output logic [WIDTH-1:0]     j,
    output logic [WIDTH-1:0]     k,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       j_reg, j_next;
    logic [WIDTH-1:0]       k_reg, k_next;
    logic                   done_reg, done_next;
    logic                   err_reg, err_next;
    logic [ERR_CNT_W-1:0]   err_cnt_reg, err_cnt_next;
    logic [3:0]             retry_reg, retry_next;
    logic [WIDTH-1:0]       tgt_reg, tgt_next;

    logic [WIDTH-1:0]       exc_tgt;
    logic [WIDTH-1:0]       exc_j;
    logic [WIDTH-1:0]       exc_k;

    // One excitation instance serves both the first drive (fresh tgt_data) and retries (latched target).
    assign exc_tgt = (state_reg == IDLE) ? tgt_data : tgt_reg;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q   (q_fb),
        .tgt (exc_tgt),
        .j   (exc_j),
        .k   (exc_k)
    );

    assign tgt_ready = (state_reg == IDLE) && !rst;
    assign j         = j_reg;
    assign k         = k_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            j_reg       <= '0;
            k_reg       <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
            retry_reg   <= '0;
            tgt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            j_reg       <= j_next;
            k_reg       <= k_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
            retry_reg   <= retry_next;
            tgt_reg     <= tgt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        j_next       = '0;
        k_next       = '0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;
        retry_next   = retry_reg;
        tgt_next     = tgt_reg;

        case (state_reg)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_next   = tgt_data;
                    j_next     = exc_j;
                    k_next     = exc_k;
                    state_next = DRIVE;
                end
            end
            // j/k return to hold so the bank is stable while we inspect it in CHECK.
            DRIVE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_reg) begin
                    done_next  = 1'b1;
                    retry_next = '0;
                    state_next = IDLE;
                end else if (retry_reg < RETRY_LIMIT) begin
                    retry_next = retry_reg + 4'd1;
                    j_next     = exc_j;
                    k_next     = exc_k;
                    state_next = DRIVE;
                end else begin
                    err_next = 1'b1;
                    if (err_cnt_reg != '1) begin
                        err_cnt_next = err_cnt_reg + 1'b1;
                    end
                    retry_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed bench for jk_drive_seq with a 4-flop JK bank model closing the q_fb loop.
// Expected j/k words are hand-derived for both the default and JK_TOGGLE_EN builds.
module tb_jk_drive_seq;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             done;
    logic             err;
    logic [7:0]       err_cnt;

    logic [WIDTH-1:0] q_bank = '0;
    logic             stuck0 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_drive_seq #(.WIDTH(WIDTH), .MAX_RETRY(2), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    // Behavioural JK bank; bit0 can be forced stuck at 0. Not reset by rst.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH; b++) begin
            case ({j[b], k[b]})
                2'b00: q_bank[b] <= q_bank[b];
                2'b01: q_bank[b] <= 1'b0;
                2'b10: q_bank[b] <= 1'b1;
                default: q_bank[b] <= ~q_bank[b];
            endcase
        end
        if (stuck0) q_bank[0] <= 1'b0;
    end
    assign q_fb = q_bank;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one accept/drive/check transaction with no faults and checks every cycle.
    task automatic run_target(input string tag, input logic [3:0] data,
                              input logic [3:0] exp_j, input logic [3:0] exp_k);
        check({tag, " ready_before"}, 32'(tgt_ready), 32'd1);
        tgt_valid = 1'b1;
        tgt_data  = data;
        tick();
        tgt_valid = 1'b0;
        check({tag, " j_drive"}, 32'(j), 32'(exp_j));
        check({tag, " k_drive"}, 32'(k), 32'(exp_k));
        check({tag, " ready_drive"}, 32'(tgt_ready), 32'd0);
        tick();
        check({tag, " jk_check"}, 32'({j, k}), 32'd0);
        check({tag, " q_after_e1"}, 32'(q_fb), 32'(data));
        check({tag, " done_early"}, 32'(done), 32'd0);
        tick();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " ready_after"}, 32'(tgt_ready), 32'd1);
        tick();
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        tick();
        tick();
        check("rst ready", 32'(tgt_ready), 32'd0);
        check("rst jk", 32'({j, k}), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst err_cnt", 32'(err_cnt), 32'd0);
        check("rst bank", 32'(q_fb), 32'd0);
        rst       = 1'b0;
        tgt_valid = 1'b0;
        tick();

`ifdef JK_TOGGLE_EN
        run_target("t1010", 4'b1010, 4'b1010, 4'b1111);
        run_target("t0110", 4'b0110, 4'b1110, 4'b1101);
`else
        run_target("t1010", 4'b1010, 4'b1010, 4'b0000);
        run_target("t0110", 4'b0110, 4'b0100, 4'b1000);
`endif

        // Stuck bit0: three drive attempts then an error.
        stuck0    = 1'b1;
        tgt_valid = 1'b1;
        tgt_data  = 4'b0001;
        for (int a = 0; a < 3; a++) begin
            tick();
            tgt_valid = 1'b0;
            check($sformatf("stuck drive%0d j0", a), 32'(j[0]), 32'd1);
            check($sformatf("stuck drive%0d done", a), 32'(done), 32'd0);
            tick();
            check($sformatf("stuck check%0d jk", a), 32'({j, k}), 32'd0);
            check($sformatf("stuck check%0d err", a), 32'(err), 32'd0);
        end
        tick();
        check("stuck err", 32'(err), 32'd1);
        check("stuck done", 32'(done), 32'd0);
        check("stuck err_cnt", 32'(err_cnt), 32'd1);
        check("stuck ready", 32'(tgt_ready), 32'd1);
        tick();
        check("stuck err_end", 32'(err), 32'd0);
        stuck0 = 1'b0;

        // Reset during DRIVE aborts the target silently.
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        tick();
        tgt_valid = 1'b0;
        check("abort j_drive", 32'(j), 32'hF);
        rst = 1'b1;
        tick();
        check("abort jk", 32'({j, k}), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort err", 32'(err), 32'd0);
        check("abort err_cnt", 32'(err_cnt), 32'd0);
        check("abort ready_in_rst", 32'(tgt_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort ready_idle", 32'(tgt_ready), 32'd1);
        tick();
        check("abort no_done", 32'({done, err}), 32'd0);
        check("abort bank", 32'(q_fb), 32'hF);
`ifdef JK_TOGGLE_EN
        run_target("t0011", 4'b0011, 4'b1111, 4'b1100);
`else
        run_target("t0011", 4'b0011, 4'b0000, 4'b1100);
`endif

        // Back-to-back with tgt_valid held high.
        tgt_valid = 1'b1;
        tgt_data  = 4'b0101;
        tick();
        tgt_data = 4'b1100;
`ifdef JK_TOGGLE_EN
        check("b2b first j", 32'(j), 32'b0111);
        check("b2b first k", 32'(k), 32'b1110);
`else
        check("b2b first j", 32'(j), 32'b0100);
        check("b2b first k", 32'(k), 32'b0010);
`endif
        tick();
        check("b2b ready +1", 32'(tgt_ready), 32'd0);
        tick();
        check("b2b ready +2", 32'(tgt_ready), 32'd1);
        check("b2b done1", 32'(done), 32'd1);
        check("b2b q1", 32'(q_fb), 32'b0101);
        tick();
        tgt_valid = 1'b0;
        check("b2b ready +3", 32'(tgt_ready), 32'd0);
`ifdef JK_TOGGLE_EN
        check("b2b second j", 32'(j), 32'b1101);
        check("b2b second k", 32'(k), 32'b1011);
`else
        check("b2b second j", 32'(j), 32'b1000);
        check("b2b second k", 32'(k), 32'b0001);
`endif
        tick();
        tick();
        check("b2b done2", 32'(done), 32'd1);
        check("b2b q2", 32'(q_fb), 32'b1100);
        check("b2b err_cnt", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
